gayle_xfer_ctrl: RTL and testbench
==================================

# gayle_xfer_ctrl

Sector-transfer sequencer for the Gayle IDE data path. It sits between the IDE task-file/command decoder, the CPU data-register port, the host (ARM/SPI) side and the 16-bit sector FIFO. It owns the FIFO read and write strobes, sequences multi-sector PIO reads and writes one 512-byte sector (256 words) at a time, and generates the ATA-style BSY, DRQ and IRQ status bits.

## Interface
Parameters: none (sector size fixed at 256 words).
- clk  in  1  bus clock
- clk7_en  in  1  clock enable; all state updates only when high
- reset_n  in  1  synchronous, active-low reset
- cmd_start  in  1  start transfer (one enable-cycle pulse from command decoder)
- cmd_write  in  1  direction, sampled with cmd_start: 1 = CPU→drive, 0 = drive→CPU
- sector_count  in  8  sectors to move, sampled with cmd_start; 0 means 256
- abort  in  1  terminate transfer (device reset / new command)
- irq_ack  in  1  status-register read; clears irq
- cpu_data_rd  in  1  CPU read of data register
- cpu_data_wr  in  1  CPU write of data register
- host_fifo_rd  in  1  host reads a word from FIFO
- host_fifo_wr  in  1  host writes a word to FIFO
- fifo_full  in  1  FIFO holds ≥ 1 sector
- fifo_empty  in  1  FIFO empty
- fifo_last  in  1  FIFO output pointer on last word of sector
- fifo_rd  out  1  FIFO read strobe
- fifo_wr  out  1  FIFO write strobe
- fifo_clr  out  1  FIFO reset pulse
- host_req_fill  out  1  host must supply a sector
- host_req_drain  out  1  host must consume a sector
- bsy  out  1  ATA BSY
- drq  out  1  ATA DRQ
- irq  out  1  interrupt request, sticky
- err  out  1  sticky protocol-violation flag
- sectors_left  out  9  remaining sectors, 0..256

## Operation
- States: IDLE, H_FILL, C_DRAIN, C_FILL, H_DRAIN.
- IDLE + cmd_start:
  - load sectors_left = (sector_count==0) ? 256 : sector_count
  - pulse fifo_clr for one enable cycle; clear err and irq
  - go to H_FILL if cmd_write=0, else C_FILL
- H_FILL (read): host_req_fill=1, bsy=1. Host writes are passed to fifo_wr. Go to C_DRAIN on fifo_full=1; set irq on entry.
- C_DRAIN: drq=1. fifo_rd = cpu_data_rd.
  - On cpu_data_rd & fifo_last: decrement sectors_left.
  - Result 0 → IDLE; otherwise → H_FILL.
- C_FILL (write): drq=1. fifo_wr = cpu_data_wr. An 8-bit word counter increments per write.
  - On the write with counter==255: clear counter, go to H_DRAIN.
- H_DRAIN: host_req_drain=1, bsy=1. fifo_rd = host_fifo_rd.
  - On fifo_empty=1: decrement sectors_left and set irq.
  - Result 0 → IDLE; otherwise → C_FILL.
- FIFO strobe mux:
  - fifo_rd = (C_DRAIN & cpu_data_rd) | (H_DRAIN & host_fifo_rd)
  - fifo_wr = (C_FILL & cpu_data_wr) | (H_FILL & host_fifo_wr)
  - All other accesses are dropped.
- Dropped CPU data accesses (drq=0) set err. Dropped host accesses are ignored silently.
- irq clears on irq_ack or cmd_start. A set and an irq_ack in the same cycle: set wins.
- abort (any state): go to IDLE, pulse fifo_clr, sectors_left=0, drq=bsy=0, word counter=0; irq and err retained. abort has priority over cmd_start and every other event in that cycle.
- cmd_start outside IDLE is ignored.

## Timing
- Reset (reset_n=0 on a clk7_en cycle): state IDLE, every output 0, sectors_left=0, word counter 0.
- Reset has priority over abort.
- Registered outputs (state flags, irq, err, sectors_left, fifo_clr) change one enable cycle after the causing event.
- fifo_rd and fifo_wr are combinational from current state and inputs, with zero latency. The FIFO applies clk7_en itself.
- After the last host write of a sector, fifo_full rises one enable later; drq rises one enable after that.
- The FIFO empty flag lags writes by one cycle. The H_DRAIN exit must use fifo_empty only; no early exit is permitted.
- On the final sector, bsy and drq are both 0 one enable after the completing event.
- bsy and drq are never both 1.

## Test plan
- Read, 1 sector: cmd_start, cmd_write=0, count=1 → host_req_fill=1. Host writes 256 words → drq=1, irq=1. CPU reads 256 words with matching data → state IDLE, drq=0, sectors_left=0.
- Read, count=0: sectors_left=256 after start. Bench runs 2 sectors, then abort → fifo_clr pulse, IDLE, sectors_left=0, irq still 1.
- Write, 3 sectors: drq=1 immediately. 256 CPU writes → drq=0, host_req_drain=1. Host drains the FIFO → irq=1, sectors_left=2. Repeat until sectors_left=0 and IDLE.
- Violation: cpu_data_rd in H_FILL → fifo_rd=0, err=1. err clears on next cmd_start.
- Simultaneous events:
  - irq_ack in the same cycle as an irq set → irq=1.
  - cmd_start with abort → IDLE, no transfer.
  - cmd_start during C_DRAIN → ignored.
- Reset mid-transfer: reset_n=0 in C_FILL after 100 words → all outputs 0. A following cmd_start write restarts with word counter 0.

Source files
------------

// File: rtl/gayle_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// gayle_xfer_ctrl
//
// Sector-transfer sequencer for the Gayle IDE data path. Moves PIO data one
// 256-word sector at a time between the CPU data-register port and the host
// side through the shared 16-bit sector FIFO. It owns the FIFO strobes and
// produces the ATA BSY/DRQ/IRQ status bits plus a sticky protocol-error flag.
//
// Ports
//   clk, clk7_en, reset_n    bus clock, clock enable, sync active-low reset
//   cmd_start, cmd_write     start pulse and direction (1 = CPU -> drive)
//   sector_count[7:0]        sectors to move, 0 means 256
//   abort                    terminate any transfer, back to IDLE
//   irq_ack                  status read, clears irq
//   cpu_data_rd/wr           CPU data-register accesses
//   host_fifo_rd/wr          host-side FIFO accesses
//   fifo_full/empty/last     FIFO status (full = one sector present,
//                            last = output pointer on the sector's last word)
//   fifo_rd, fifo_wr         FIFO strobes, combinational, unqualified by
//                            clk7_en (the FIFO applies the enable itself)
//   fifo_clr                 one-enable-cycle FIFO reset pulse
//   host_req_fill/drain      host must supply / consume a sector
//   bsy, drq, irq, err       ATA status bits and sticky violation flag
//   sectors_left[8:0]        remaining sectors, 0..256
//
// Strobe semantics: a data access is accepted in the cycle its request is
// high and the current state routes it to the FIFO; there is no back-pressure,
// every other access is dropped in that same cycle.
// -----------------------------------------------------------------------------
module gayle_xfer_ctrl (
    input  logic       clk,
    input  logic       clk7_en,
    input  logic       reset_n,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic [7:0] sector_count,
    input  logic       abort,
    input  logic       irq_ack,
    input  logic       cpu_data_rd,
    input  logic       cpu_data_wr,
    input  logic       host_fifo_rd,
    input  logic       host_fifo_wr,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    input  logic       fifo_last,
    output logic       fifo_rd,
    output logic       fifo_wr,
    output logic       fifo_clr,
    output logic       host_req_fill,
    output logic       host_req_drain,
    output logic       bsy,
    output logic       drq,
    output logic       irq,
    output logic       err,
    output logic [8:0] sectors_left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        H_FILL  = 3'd1,
        C_DRAIN = 3'd2,
        C_FILL  = 3'd3,
        H_DRAIN = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] word_cnt;

    logic       start_ok;
    logic       irq_set;
    logic       cpu_drop;
    logic [8:0] sl_dec;

    // Status flags are a direct decode of the state register, so they move
    // exactly one enable cycle after the event that changed the state, and
    // bsy/drq can never be high together.
    assign host_req_fill  = (state == H_FILL);
    assign host_req_drain = (state == H_DRAIN);
    assign bsy            = host_req_fill | host_req_drain;
    assign drq            = (state == C_DRAIN) | (state == C_FILL);

    // FIFO strobe mux; anything not routed here is dropped.
    assign fifo_rd = ((state == C_DRAIN) & cpu_data_rd) |
                     ((state == H_DRAIN) & host_fifo_rd);
    assign fifo_wr = ((state == C_FILL)  & cpu_data_wr) |
                     ((state == H_FILL)  & host_fifo_wr);

    assign start_ok = cmd_start & (state == IDLE);
    assign irq_set  = ((state == H_FILL)  & fifo_full) |
                      ((state == H_DRAIN) & fifo_empty);
    // Only CPU accesses while DRQ is low count as violations.
    assign cpu_drop = (cpu_data_rd | cpu_data_wr) & ~drq;
    assign sl_dec   = sectors_left - 9'd1;

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (!reset_n) begin
                state        <= IDLE;
                word_cnt     <= 8'd0;
                sectors_left <= 9'd0;
                fifo_clr     <= 1'b0;
                irq          <= 1'b0;
                err          <= 1'b0;
            end else if (abort) begin
                // Abort wins over everything but reset; irq and err are kept
                // so software can still see why the transfer ended.
                state        <= IDLE;
                word_cnt     <= 8'd0;
                sectors_left <= 9'd0;
                fifo_clr     <= 1'b1;
            end else begin
                fifo_clr <= start_ok;

                // A set in the same cycle as an acknowledge wins.
                if (irq_set) begin
                    irq <= 1'b1;
                end else if (irq_ack || start_ok) begin
                    irq <= 1'b0;
                end

                if (cpu_drop) begin
                    err <= 1'b1;
                end else if (start_ok) begin
                    err <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (cmd_start) begin
                            sectors_left <= (sector_count == 8'd0) ? 9'd256
                                                                    : {1'b0, sector_count};
                            word_cnt     <= 8'd0;
                            state        <= cmd_write ? C_FILL : H_FILL;
                        end
                    end
                    H_FILL: begin
                        if (fifo_full) begin
                            state <= C_DRAIN;
                        end
                    end
                    C_DRAIN: begin
                        if (cpu_data_rd && fifo_last) begin
                            sectors_left <= sl_dec;
                            state        <= (sl_dec == 9'd0) ? IDLE : H_FILL;
                        end
                    end
                    C_FILL: begin
                        // The FIFO full flag is too late to end a CPU fill
                        // cleanly, so the sector boundary is counted here.
                        if (cpu_data_wr) begin
                            if (word_cnt == 8'd255) begin
                                word_cnt <= 8'd0;
                                state    <= H_DRAIN;
                            end else begin
                                word_cnt <= word_cnt + 8'd1;
                            end
                        end
                    end
                    H_DRAIN: begin
                        // Exit strictly on the (lagging) empty flag.
                        if (fifo_empty) begin
                            sectors_left <= sl_dec;
                            state        <= (sl_dec == 9'd0) ? IDLE : C_FILL;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gayle_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gayle_xfer_ctrl
//
// Bench for gayle_xfer_ctrl. A small behavioural sector FIFO reacts to the
// DUT strobes; every word written towards the FIFO is pushed on exp_q and
// every word the FIFO hands out is compared against the front of exp_q.
// Single-cycle control behaviour is covered by a vector table, the multi-cycle
// transfers by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_gayle_xfer_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clk7_en;
    logic       reset_n;
    logic       cmd_start;
    logic       cmd_write;
    logic [7:0] sector_count;
    logic       abort;
    logic       irq_ack;
    logic       cpu_data_rd;
    logic       cpu_data_wr;
    logic       host_fifo_rd;
    logic       host_fifo_wr;
    logic       fifo_full  = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_last  = 1'b0;
    logic       fifo_rd;
    logic       fifo_wr;
    logic       fifo_clr;
    logic       host_req_fill;
    logic       host_req_drain;
    logic       bsy;
    logic       drq;
    logic       irq;
    logic       err;
    logic [8:0] sectors_left;

    gayle_xfer_ctrl dut (
        .clk            (clk),
        .clk7_en        (clk7_en),
        .reset_n        (reset_n),
        .cmd_start      (cmd_start),
        .cmd_write      (cmd_write),
        .sector_count   (sector_count),
        .abort          (abort),
        .irq_ack        (irq_ack),
        .cpu_data_rd    (cpu_data_rd),
        .cpu_data_wr    (cpu_data_wr),
        .host_fifo_rd   (host_fifo_rd),
        .host_fifo_wr   (host_fifo_wr),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_last      (fifo_last),
        .fifo_rd        (fifo_rd),
        .fifo_wr        (fifo_wr),
        .fifo_clr       (fifo_clr),
        .host_req_fill  (host_req_fill),
        .host_req_drain (host_req_drain),
        .bsy            (bsy),
        .drq            (drq),
        .irq            (irq),
        .err            (err),
        .sectors_left   (sectors_left)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mem_q[$];
    logic [15:0] wr_data = 16'h0;
    logic [15:0] model_word;
    int          rd_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural sector FIFO ----------------
    always @(posedge clk) begin
        if (clk7_en) begin
            if (fifo_clr) begin
                mem_q.delete();
                rd_cnt = 0;
            end else begin
                if (fifo_rd) begin
                    if (mem_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL fifo_underflow: got read of empty fifo expected no read (t=%0t)", $time);
                    end else begin
                        model_word = mem_q.pop_front();
                        rd_cnt = (rd_cnt + 1) % 256;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL scoreboard_empty: got %0h expected no word (t=%0t)", model_word, $time);
                        end else begin
                            check("fifo_data", {16'h0, model_word}, {16'h0, exp_q.pop_front()});
                        end
                    end
                end
                if (fifo_wr) begin
                    mem_q.push_back(wr_data);
                end
            end
            fifo_full  <= (mem_q.size() >= 256);
            fifo_empty <= (mem_q.size() == 0);
            fifo_last  <= (rd_cnt == 255);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        cmd_start    = 1'b0;
        cmd_write    = 1'b0;
        sector_count = 8'd0;
        abort        = 1'b0;
        irq_ack      = 1'b0;
        cpu_data_rd  = 1'b0;
        cpu_data_wr  = 1'b0;
        host_fifo_rd = 1'b0;
        host_fifo_wr = 1'b0;
    endtask

    // Present the current inputs to one rising edge, then return them to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic start_cmd(input logic wr, input logic [7:0] cnt);
        cmd_start    = 1'b1;
        cmd_write    = wr;
        sector_count = cnt;
        tick();
    endtask

    task automatic host_write_words(input int n);
        for (int i = 0; i < n; i++) begin
            host_fifo_wr = 1'b1;
            wr_data      = 16'($urandom_range(0, 65535));
            exp_q.push_back(wr_data);
            tick();
        end
    endtask

    task automatic cpu_write_words(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_data_wr = 1'b1;
            wr_data     = 16'($urandom_range(0, 65535));
            exp_q.push_back(wr_data);
            tick();
        end
    endtask

    task automatic cpu_read_words(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_data_rd = 1'b1;
            tick();
        end
    endtask

    task automatic host_read_words(input int n);
        for (int i = 0; i < n; i++) begin
            host_fifo_rd = 1'b1;
            tick();
        end
    endtask

    function automatic logic [15:0] r(input logic clr, fill, drain, b, d, i, e,
                                      input logic [8:0] sl);
        return {clr, fill, drain, b, d, i, e, sl};
    endfunction

    function automatic logic [15:0] regs_now();
        return {fifo_clr, host_req_fill, host_req_drain, bsy, drq, irq, err, sectors_left};
    endfunction

    task automatic check_regs(input string name, input logic [15:0] exp);
        check(name, {16'h0, regs_now()}, {16'h0, exp});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        cs;
        logic        cw;
        logic [7:0]  cnt;
        logic        ab;
        logic        ack;
        logic        crd;
        logic        cwr;
        logic        hrd;
        logic        hwr;
        logic [1:0]  exp_strobe;   // {fifo_rd, fifo_wr} before the edge
        logic [15:0] exp_regs;     // registered outputs after the edge
    } vec_t;

    function automatic vec_t mk(input logic cs, cw, input logic [7:0] cnt,
                                input logic ab, ack, crd, cwr, hrd, hwr,
                                input logic [1:0] es, input logic [15:0] er);
        vec_t v;
        v.cs = cs; v.cw = cw; v.cnt = cnt; v.ab = ab; v.ack = ack;
        v.crd = crd; v.cwr = cwr; v.hrd = hrd; v.hwr = hwr;
        v.exp_strobe = es; v.exp_regs = er;
        return v;
    endfunction

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "time limit");
    end

    // ---------------- main test ----------------
    initial begin
        //        cs  cw  cnt    ab  ack crd cwr hrd hwr  strobe  regs after edge
        vecs[0]  = mk(0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 2'b00, r(0,0,0,0,0,0,0,9'd0));
        vecs[1]  = mk(0, 0, 8'd0, 0, 0, 1, 0, 0, 0, 2'b00, r(0,0,0,0,0,0,1,9'd0));
        vecs[2]  = mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 0, 2'b00, r(1,1,0,1,0,0,0,9'd256));
        vecs[3]  = mk(0, 0, 8'd0, 0, 0, 1, 0, 0, 0, 2'b00, r(0,1,0,1,0,0,1,9'd256));
        vecs[4]  = mk(0, 0, 8'd0, 0, 0, 0, 0, 1, 0, 2'b00, r(0,1,0,1,0,0,1,9'd256));
        vecs[5]  = mk(1, 1, 8'd5, 0, 0, 0, 0, 0, 0, 2'b00, r(0,1,0,1,0,0,1,9'd256));
        vecs[6]  = mk(1, 1, 8'd5, 1, 0, 0, 0, 0, 0, 2'b00, r(1,0,0,0,0,0,1,9'd0));
        vecs[7]  = mk(1, 0, 8'd9, 1, 0, 0, 0, 0, 0, 2'b00, r(1,0,0,0,0,0,1,9'd0));
        vecs[8]  = mk(1, 1, 8'd3, 0, 0, 0, 0, 0, 0, 2'b00, r(1,0,0,0,1,0,0,9'd3));
        vecs[9]  = mk(0, 0, 8'd0, 0, 0, 0, 1, 0, 0, 2'b01, r(0,0,0,0,1,0,0,9'd3));
        vecs[10] = mk(0, 0, 8'd0, 0, 0, 0, 0, 0, 1, 2'b00, r(0,0,0,0,1,0,0,9'd3));
        vecs[11] = mk(0, 0, 8'd0, 0, 0, 1, 0, 0, 0, 2'b00, r(0,0,0,0,1,0,0,9'd3));
        vecs[12] = mk(0, 0, 8'd0, 0, 0, 0, 0, 1, 0, 2'b00, r(0,0,0,0,1,0,0,9'd3));
        vecs[13] = mk(0, 0, 8'd0, 1, 0, 0, 0, 0, 0, 2'b00, r(1,0,0,0,0,0,0,9'd0));
        vecs[14] = mk(0, 0, 8'd0, 0, 1, 0, 0, 0, 0, 2'b00, r(0,0,0,0,0,0,0,9'd0));
        vecs[15] = mk(0, 0, 8'd0, 0, 0, 0, 1, 0, 0, 2'b00, r(0,0,0,0,0,0,1,9'd0));

        // reset
        idle_inputs();
        clk7_en = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        check_regs("reset_state", r(0,0,0,0,0,0,0,9'd0));
        check("reset_strobes", {30'h0, fifo_rd, fifo_wr}, 32'h0);
        reset_n = 1'b1;
        tick();

        // table-driven control vectors
        for (int i = 0; i < NV; i++) begin
            cmd_start    = vecs[i].cs;
            cmd_write    = vecs[i].cw;
            sector_count = vecs[i].cnt;
            abort        = vecs[i].ab;
            irq_ack      = vecs[i].ack;
            cpu_data_rd  = vecs[i].crd;
            cpu_data_wr  = vecs[i].cwr;
            host_fifo_rd = vecs[i].hrd;
            host_fifo_wr = vecs[i].hwr;
            #1;
            check($sformatf("vec%0d_strobe", i), {30'h0, fifo_rd, fifo_wr}, {30'h0, vecs[i].exp_strobe});
            tick();
            check_regs($sformatf("vec%0d_regs", i), vecs[i].exp_regs);
        end

        // read, one sector, with irq_ack colliding with the irq set
        exp_q.delete();
        start_cmd(1'b0, 8'd1);
        check_regs("rd1_start", r(1,1,0,1,0,0,0,9'd1));
        tick();
        host_write_words(256);
        check_regs("rd1_filled_no_drq_yet", r(0,1,0,1,0,0,0,9'd1));
        irq_ack = 1'b1;
        tick();
        check_regs("rd1_drq_irq_set_wins", r(0,0,0,0,1,1,0,9'd1));
        cmd_start    = 1'b1;
        cmd_write    = 1'b1;
        sector_count = 8'd7;
        tick();
        check_regs("rd1_start_ignored", r(0,0,0,0,1,1,0,9'd1));
        irq_ack = 1'b1;
        tick();
        check_regs("rd1_irq_ack", r(0,0,0,0,1,0,0,9'd1));
        cpu_read_words(255);
        check_regs("rd1_before_last", r(0,0,0,0,1,0,0,9'd1));
        cpu_read_words(1);
        check_regs("rd1_done", r(0,0,0,0,0,0,0,9'd0));
        check("rd1_scoreboard_drained", exp_q.size(), 0);

        // read, count 0 (256 sectors): two sectors then abort
        exp_q.delete();
        start_cmd(1'b0, 8'd0);
        check_regs("rd256_start", r(1,1,0,1,0,0,0,9'd256));
        tick();
        for (int s = 0; s < 2; s++) begin
            host_write_words(256);
            tick();
            check_regs($sformatf("rd256_s%0d_drq", s), r(0,0,0,0,1,1,0,9'(256 - s)));
            cpu_read_words(256);
            check_regs($sformatf("rd256_s%0d_refill", s), r(0,1,0,1,0,1,0,9'(255 - s)));
        end
        abort = 1'b1;
        tick();
        check_regs("rd256_abort", r(1,0,0,0,0,1,0,9'd0));
        tick();
        check_regs("rd256_abort_pulse_end", r(0,0,0,0,0,1,0,9'd0));

        // clock enable low: a start must not be taken
        clk7_en = 1'b0;
        start_cmd(1'b1, 8'd3);
        check_regs("clk_en_low_hold", r(0,0,0,0,0,1,0,9'd0));
        clk7_en = 1'b1;

        // write, three sectors
        exp_q.delete();
        start_cmd(1'b1, 8'd3);
        check_regs("wr3_start", r(1,0,0,0,1,0,0,9'd3));
        tick();
        for (int s = 0; s < 3; s++) begin
            cpu_write_words(255);
            check_regs($sformatf("wr3_s%0d_word255", s), r(0,0,0,0,1,0,0,9'(3 - s)));
            cpu_write_words(1);
            check_regs($sformatf("wr3_s%0d_drain", s), r(0,0,1,1,0,0,0,9'(3 - s)));
            host_read_words(256);
            check_regs($sformatf("wr3_s%0d_no_early_exit", s), r(0,0,1,1,0,0,0,9'(3 - s)));
            tick();
            check_regs($sformatf("wr3_s%0d_done", s),
                       r(0,0,0,0,(s < 2),1,0,9'(2 - s)));
            irq_ack = 1'b1;
            tick();
            check_regs($sformatf("wr3_s%0d_ack", s), r(0,0,0,0,(s < 2),0,0,9'(2 - s)));
        end
        check("wr3_scoreboard_drained", exp_q.size(), 0);

        // reset in the middle of a write (with abort asserted too)
        exp_q.delete();
        start_cmd(1'b1, 8'd2);
        tick();
        cpu_write_words(100);
        check_regs("rst_mid_before", r(0,0,0,0,1,0,0,9'd2));
        reset_n = 1'b0;
        abort   = 1'b1;
        tick();
        check_regs("rst_mid_all_zero", r(0,0,0,0,0,0,0,9'd0));
        reset_n     = 1'b0;
        cpu_data_wr = 1'b1;
        #1;
        check("rst_mid_strobes", {30'h0, fifo_rd, fifo_wr}, 32'h0);
        tick();
        check_regs("rst_held_no_err", r(0,0,0,0,0,0,0,9'd0));
        reset_n = 1'b1;
        exp_q.delete();
        start_cmd(1'b1, 8'd1);
        check_regs("rst_restart", r(1,0,0,0,1,0,0,9'd1));
        tick();
        cpu_write_words(255);
        check_regs("rst_restart_word255", r(0,0,0,0,1,0,0,9'd1));
        cpu_write_words(1);
        check_regs("rst_restart_drain", r(0,0,1,1,0,0,0,9'd1));
        host_read_words(256);
        tick();
        check_regs("rst_restart_done", r(0,0,0,0,0,1,0,9'd0));
        check("rst_scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
